// File: rtl/jtag_axi_seq_pkg.sv
// Shared types and constants for the JTAG debug-module to AXI4-Lite sequencer.
package jtag_axi_seq_pkg;

  typedef enum logic [2:0] {
    JSEQ_IDLE  = 3'd0,
    JSEQ_WR    = 3'd1,
    JSEQ_WRESP = 3'd2,
    JSEQ_RADDR = 3'd3,
    JSEQ_RDATA = 3'd4,
    JSEQ_RSP   = 3'd5
  } jseq_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam int unsigned MEM_ADDR_W = 32;
  localparam int unsigned MEM_DATA_W = 32;

  function automatic logic [MEM_ADDR_W-1:0] word_align(input logic [MEM_ADDR_W-1:0] a);
    return a & ~MEM_ADDR_W'(3);
  endfunction

  function automatic logic resp_is_err(input logic [1:0] r);
    return (r == AXI_RESP_SLVERR) || (r == AXI_RESP_DECERR);
  endfunction

endpackage

// File: rtl/jtag_axi_seq_wdt.sv
// Transaction watchdog: clearable counter that flags when the wait budget is spent.
module jtag_axi_wdt #(
  parameter int unsigned TIMEOUT_CYC = 1023,
  parameter int unsigned TO_W        = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT_CYC);

  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + TO_W'(1);
    end
  end

  // A zero budget disables the watchdog entirely.
  assign expire = (TIMEOUT_CYC != 0) && en && (cnt == LIMIT);

endmodule

// File: rtl/jtag_axi_seq.sv
// Single-outstanding sequencer turning DM memory requests into AXI4-Lite transactions.
module jtag_axi_seq
  import jtag_axi_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1023,
  parameter int unsigned TO_W        = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [MEM_ADDR_W-1:0] req_addr_i,
  input  logic [MEM_DATA_W-1:0] req_wdata_i,
  input  logic [3:0]            req_sel_i,
  output logic                  rsp_valid_o,
  output logic [MEM_DATA_W-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  rsp_timeout_o,
  output logic [MEM_ADDR_W-1:0] m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [MEM_DATA_W-1:0] m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [MEM_ADDR_W-1:0] m_axi_araddr,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [MEM_DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  jseq_state_e state_q, state_d;

  logic [MEM_ADDR_W-1:0] addr_q;
  logic [MEM_DATA_W-1:0] wdata_q;
  logic [3:0]            sel_q;
  logic                  aw_done_q, w_done_q;
  logic                  aw_hs, w_hs;

  logic                  accept, wdt_en, wdt_expire;
  logic                  rsp_load, rsp_err_d, rsp_to_d;
  logic [MEM_DATA_W-1:0] rsp_rdata_d;
  logic [MEM_DATA_W-1:0] rsp_rdata_q;
  logic                  rsp_err_q, rsp_to_q;

  jtag_axi_wdt #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TO_W       (TO_W)
  ) u_wdt (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .en    (wdt_en),
    .expire(wdt_expire)
  );

  // Bus-facing strobes come only from registered state, never from AXI inputs.
  assign req_ready_o   = (state_q == JSEQ_IDLE) && !rst;
  assign m_axi_awvalid = (state_q == JSEQ_WR) && !aw_done_q;
  assign m_axi_wvalid  = (state_q == JSEQ_WR) && !w_done_q;
  assign m_axi_bready  = (state_q == JSEQ_WRESP);
  assign m_axi_arvalid = (state_q == JSEQ_RADDR);
  assign m_axi_rready  = (state_q == JSEQ_RDATA);
  assign rsp_valid_o   = (state_q == JSEQ_RSP);

  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_awprot  = 3'h0;
  assign m_axi_arprot  = 3'h0;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = sel_q;

  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_to_q;

  assign aw_hs = m_axi_awvalid && m_axi_awready;
  assign w_hs  = m_axi_wvalid && m_axi_wready;

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    wdt_en      = 1'b0;
    rsp_load    = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_to_d    = 1'b0;
    rsp_rdata_d = '0;
    case (state_q)
      JSEQ_IDLE: begin
        if (req_valid_i) begin
          accept  = 1'b1;
          state_d = req_we_i ? JSEQ_WR : JSEQ_RADDR;
        end
      end
      JSEQ_WR: begin
        wdt_en = 1'b1;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d = JSEQ_WRESP;
        end else if (wdt_expire) begin
          state_d  = JSEQ_RSP;
          rsp_load = 1'b1; rsp_err_d = 1'b1; rsp_to_d = 1'b1;
        end
      end
      JSEQ_WRESP: begin
        wdt_en = 1'b1;
        if (m_axi_bvalid) begin
          state_d   = JSEQ_RSP;
          rsp_load  = 1'b1;
          rsp_err_d = resp_is_err(m_axi_bresp);
        end else if (wdt_expire) begin
          state_d  = JSEQ_RSP;
          rsp_load = 1'b1; rsp_err_d = 1'b1; rsp_to_d = 1'b1;
        end
      end
      JSEQ_RADDR: begin
        wdt_en = 1'b1;
        if (m_axi_arready) begin
          state_d = JSEQ_RDATA;
        end else if (wdt_expire) begin
          state_d  = JSEQ_RSP;
          rsp_load = 1'b1; rsp_err_d = 1'b1; rsp_to_d = 1'b1;
        end
      end
      JSEQ_RDATA: begin
        wdt_en = 1'b1;
        if (m_axi_rvalid) begin
          state_d     = JSEQ_RSP;
          rsp_load    = 1'b1;
          rsp_err_d   = resp_is_err(m_axi_rresp);
          rsp_rdata_d = rsp_err_d ? '0 : m_axi_rdata;
        end else if (wdt_expire) begin
          state_d  = JSEQ_RSP;
          rsp_load = 1'b1; rsp_err_d = 1'b1; rsp_to_d = 1'b1;
        end
      end
      JSEQ_RSP: state_d = JSEQ_IDLE;
      default:  state_d = JSEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= JSEQ_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      sel_q       <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q    <= word_align(req_addr_i);
        wdata_q   <= req_wdata_i;
        sel_q     <= req_sel_i;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end else begin
        aw_done_q <= aw_done_q || aw_hs;
        w_done_q  <= w_done_q || w_hs;
      end
      if (rsp_load) begin
        rsp_rdata_q <= rsp_rdata_d;
        rsp_err_q   <= rsp_err_d;
        rsp_to_q    <= rsp_to_d;
      end
    end
  end

endmodule

// File: tb/tb_jtag_axi_seq.sv
// Directed bench for jtag_axi_seq: the bench plays the AXI slave cycle by cycle.
module tb_jtag_axi_seq;
  import jtag_axi_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i, req_ready_o, req_we_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [3:0]  req_sel_i;
  logic        rsp_valid_o, rsp_err_o, rsp_timeout_o;
  logic [31:0] rsp_rdata_o;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [3:0]  m_axi_wstrb;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;

  int unsigned total = 0;
  int unsigned passed = 0;

  always #5 clk = ~clk;

  jtag_axi_seq #(
    .TIMEOUT_CYC(8),
    .TO_W       (4)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_sel_i(req_sel_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .rsp_timeout_o(rsp_timeout_o),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] sel);
    req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr; req_wdata_i = wd; req_sel_i = sel;
  endtask

  initial begin
    rst = 1'b1;
    req_valid_i = 0; req_we_i = 0; req_addr_i = '0; req_wdata_i = '0; req_sel_i = '0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = AXI_RESP_OKAY;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = AXI_RESP_OKAY;

    // Reset state
    tick(); tick();
    chk1("rst_req_ready", req_ready_o, 1'b0);
    chk1("rst_awvalid", m_axi_awvalid, 1'b0);
    chk1("rst_arvalid", m_axi_arvalid, 1'b0);
    chk1("rst_rsp_valid", rsp_valid_o, 1'b0);
    chk("rst_rdata", rsp_rdata_o, 32'h0);
    rst = 1'b0;
    tick();

    // 1: write, always-ready slave
    req(1'b1, 32'h2000_0006, 32'hA5A5_1234, 4'b1100);
    m_axi_awready = 1; m_axi_wready = 1;
    chk1("t1_ready_idle", req_ready_o, 1'b1);
    tick();
    req_valid_i = 0;
    chk1("t1_awvalid", m_axi_awvalid, 1'b1);
    chk1("t1_wvalid", m_axi_wvalid, 1'b1);
    chk("t1_awaddr", m_axi_awaddr, 32'h2000_0004);
    chk("t1_wdata", m_axi_wdata, 32'hA5A5_1234);
    chk("t1_wstrb", {28'h0, m_axi_wstrb}, 32'hC);
    chk("t1_awprot", {29'h0, m_axi_awprot}, 32'h0);
    chk1("t1_bready_early", m_axi_bready, 1'b0);
    tick();
    m_axi_awready = 0; m_axi_wready = 0;
    chk1("t1_bready", m_axi_bready, 1'b1);
    chk1("t1_aw_dropped", m_axi_awvalid, 1'b0);
    m_axi_bvalid = 1; m_axi_bresp = AXI_RESP_OKAY;
    tick();
    m_axi_bvalid = 0;
    chk1("t1_rsp_valid", rsp_valid_o, 1'b1);
    chk1("t1_rsp_err", rsp_err_o, 1'b0);
    chk1("t1_rsp_to", rsp_timeout_o, 1'b0);
    chk("t1_rsp_rdata", rsp_rdata_o, 32'h0);
    chk1("t1_ready_in_rsp", req_ready_o, 1'b0);
    tick();
    chk1("t1_rsp_pulse_end", rsp_valid_o, 1'b0);
    chk1("t1_ready_after", req_ready_o, 1'b1);

    // 2: AWREADY delayed, WREADY immediate, early BVALID ignored
    req(1'b1, 32'h1000_0010, 32'h1122_3344, 4'b1111);
    m_axi_wready = 1;
    tick();
    req_valid_i = 0;
    chk1("t2_aw_c1", m_axi_awvalid, 1'b1);
    chk1("t2_w_c1", m_axi_wvalid, 1'b1);
    tick();
    m_axi_wready = 0;
    chk1("t2_w_dropped", m_axi_wvalid, 1'b0);
    for (int i = 2; i <= 5; i++) begin
      m_axi_bvalid = (i == 3);
      m_axi_bresp  = AXI_RESP_SLVERR;
      chk1($sformatf("t2_aw_held_c%0d", i), m_axi_awvalid, 1'b1);
      chk1($sformatf("t2_bready_low_c%0d", i), m_axi_bready, 1'b0);
      chk1($sformatf("t2_no_rsp_c%0d", i), rsp_valid_o, 1'b0);
      tick();
    end
    m_axi_bvalid = 0;
    m_axi_awready = 1;
    chk1("t2_aw_c6", m_axi_awvalid, 1'b1);
    tick();
    m_axi_awready = 0;
    chk1("t2_aw_dropped", m_axi_awvalid, 1'b0);
    chk1("t2_bready", m_axi_bready, 1'b1);
    m_axi_bvalid = 1; m_axi_bresp = AXI_RESP_DECERR;
    tick();
    m_axi_bvalid = 0;
    chk1("t2_rsp_valid", rsp_valid_o, 1'b1);
    chk1("t2_rsp_err", rsp_err_o, 1'b1);
    tick();

    // 3: read, ARREADY after 2 cycles, SLVERR
    req(1'b0, 32'h8000_0000, 32'h0, 4'h0);
    tick();
    req_valid_i = 0;
    chk1("t3_arvalid_c1", m_axi_arvalid, 1'b1);
    chk("t3_araddr", m_axi_araddr, 32'h8000_0000);
    chk1("t3_rready_low", m_axi_rready, 1'b0);
    tick();
    m_axi_arready = 1;
    chk1("t3_arvalid_c2", m_axi_arvalid, 1'b1);
    tick();
    m_axi_arready = 0;
    chk1("t3_ar_dropped", m_axi_arvalid, 1'b0);
    chk1("t3_rready", m_axi_rready, 1'b1);
    m_axi_rvalid = 1; m_axi_rdata = 32'hDEAD_BEEF; m_axi_rresp = AXI_RESP_SLVERR;
    tick();
    m_axi_rvalid = 0;
    chk1("t3_rsp_valid", rsp_valid_o, 1'b1);
    chk1("t3_rsp_err", rsp_err_o, 1'b1);
    chk("t3_rsp_rdata", rsp_rdata_o, 32'h0);
    tick();

    // 3b: read with OKAY returns data
    req(1'b0, 32'h0000_0007, 32'h0, 4'h0);
    m_axi_arready = 1;
    tick();
    req_valid_i = 0;
    chk("t3b_araddr", m_axi_araddr, 32'h0000_0004);
    tick();
    m_axi_arready = 0;
    m_axi_rvalid = 1; m_axi_rdata = 32'h1234_5678; m_axi_rresp = AXI_RESP_OKAY;
    tick();
    m_axi_rvalid = 0;
    chk1("t3b_rsp_valid", rsp_valid_o, 1'b1);
    chk("t3b_rsp_rdata", rsp_rdata_o, 32'h1234_5678);
    chk1("t3b_rsp_err", rsp_err_o, 1'b0);
    tick();
    chk("t3b_rdata_hold", rsp_rdata_o, 32'h1234_5678);

    // 4: ARREADY never arrives -> watchdog (count 0..8 in RADDR)
    req(1'b0, 32'h4000_0000, 32'h0, 4'h0);
    tick();
    req_valid_i = 0;
    for (int i = 1; i <= 9; i++) begin
      chk1($sformatf("t4_arvalid_c%0d", i), m_axi_arvalid, 1'b1);
      chk1($sformatf("t4_no_rsp_c%0d", i), rsp_valid_o, 1'b0);
      tick();
    end
    chk1("t4_ar_dropped", m_axi_arvalid, 1'b0);
    chk1("t4_rsp_valid", rsp_valid_o, 1'b1);
    chk1("t4_rsp_to", rsp_timeout_o, 1'b1);
    chk1("t4_rsp_err", rsp_err_o, 1'b1);
    chk("t4_rsp_rdata", rsp_rdata_o, 32'h0);
    tick();
    chk1("t4_ready_after", req_ready_o, 1'b1);
    m_axi_rvalid = 1; m_axi_rdata = 32'h5555_AAAA;
    chk1("t4_late_rready", m_axi_rready, 1'b0);
    tick();
    m_axi_rvalid = 0;
    chk1("t4_late_no_rsp", rsp_valid_o, 1'b0);
    chk1("t4_late_idle", req_ready_o, 1'b1);

    // 4b: handshake on the expiry cycle wins over the timeout
    req(1'b0, 32'h4000_0100, 32'h0, 4'h0);
    tick();
    req_valid_i = 0;
    for (int i = 1; i <= 8; i++) tick();
    m_axi_arready = 1;
    chk1("t4b_arvalid_c9", m_axi_arvalid, 1'b1);
    tick();
    m_axi_arready = 0;
    chk1("t4b_rready", m_axi_rready, 1'b1);
    chk1("t4b_no_rsp", rsp_valid_o, 1'b0);
    m_axi_rvalid = 1; m_axi_rdata = 32'hCAFE_F00D; m_axi_rresp = AXI_RESP_OKAY;
    tick();
    m_axi_rvalid = 0;
    chk1("t4b_rsp_valid", rsp_valid_o, 1'b1);
    chk1("t4b_rsp_to", rsp_timeout_o, 1'b0);
    chk("t4b_rsp_rdata", rsp_rdata_o, 32'hCAFE_F00D);
    tick();

    // 5: reset while waiting for B
    req(1'b1, 32'h3000_0000, 32'hFFFF_0000, 4'b0011);
    m_axi_awready = 1; m_axi_wready = 1;
    tick();
    req_valid_i = 0;
    tick();
    m_axi_awready = 0; m_axi_wready = 0;
    chk1("t5_bready_before", m_axi_bready, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk1("t5_bready_dropped", m_axi_bready, 1'b0);
    chk1("t5_no_rsp", rsp_valid_o, 1'b0);
    chk("t5_rsp_rdata_cleared", rsp_rdata_o, 32'h0);
    tick();
    chk1("t5_no_rsp_later", rsp_valid_o, 1'b0);
    req(1'b0, 32'h0000_0200, 32'h0, 4'h0);
    m_axi_arready = 1;
    tick();
    req_valid_i = 0;
    tick();
    m_axi_arready = 0;
    m_axi_rvalid = 1; m_axi_rdata = 32'h0BAD_F00D; m_axi_rresp = AXI_RESP_EXOKAY;
    tick();
    m_axi_rvalid = 0;
    chk1("t5_read_rsp_valid", rsp_valid_o, 1'b1);
    chk("t5_read_rdata", rsp_rdata_o, 32'h0BAD_F00D);
    tick();

    // 6: back-to-back with req_valid_i held high
    req(1'b0, 32'h0000_0100, 32'h0, 4'h0);
    m_axi_arready = 1; m_axi_rvalid = 1; m_axi_rdata = 32'h7777_0001; m_axi_rresp = AXI_RESP_OKAY;
    for (int i = 0; i < 8; i++) begin
      chk1($sformatf("t6_ready_c%0d", i), req_ready_o, (i % 4) == 0);
      chk1($sformatf("t6_rsp_c%0d", i), rsp_valid_o, (i % 4) == 3);
      tick();
    end
    req_valid_i = 0;
    m_axi_arready = 0; m_axi_rvalid = 0;
    tick();
    chk1("t6_idle_end", req_ready_o, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
